// File: rtl/fp32_div_arbiter_if.sv
// Request/response, divider-side and status signals of the FP32 divider arbiter.
// Latency: none (wires only).
// Backpressure: per-requester valid/ready on the request side; the result strobe cannot be stalled.
interface fp32_div_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic [32*N_REQ-1:0] req_a_i;
    logic [32*N_REQ-1:0] req_b_i;
    logic [N_REQ-1:0]    resp_valid_o;
    logic [31:0]         resp_data_o;
    logic                resp_dbz_o;
    logic                resp_err_o;
    logic                div_valid_o;
    logic [31:0]         div_a_o;
    logic [31:0]         div_b_o;
    logic [31:0]         div_result_i;
    logic                div_done_i;
    logic                busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, div_result_i, div_done_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_dbz_o, resp_err_o,
               div_valid_o, div_a_o, div_b_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, div_result_i, div_done_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_dbz_o, resp_err_o,
               div_valid_o, div_a_o, div_b_o, busy_o
    );
endinterface

// File: rtl/fp32_div_arbiter.sv
// Round-robin arbiter sharing one FP32 divider among N_REQ requesters; optional watchdog via FP32_DIV_ARB_WDOG_EN.
// Latency: accept -> div_valid_o 1 cycle; div_done_i -> resp_valid_o 1 cycle.
// Backpressure: req_ready_o is low while an operation is in flight; responses cannot be stalled.
module fp32_div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    fp32_div_arbiter_if.slave  bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    op_t           op_q, op_d;
    logic [31:0]   result_q, result_d;
    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic          timeout;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_vld && bus.req_valid_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(rr_ptr_q) + i) % N_REQ);
            end
        end
    end

`ifdef FP32_DIV_ARB_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          err_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + CW'(1) : '0;
            if (state_q == WAIT) begin
                err_q <= timeout && !bus.div_done_i;
            end
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle; a real done in that cycle still wins.
    assign timeout = (state_q == WAIT) && (wd_cnt_q == CW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        result_d = result_q;

        bus.req_ready_o  = '0;
        bus.resp_valid_o = '0;
        bus.resp_data_o  = '0;
        bus.resp_dbz_o   = 1'b0;
        bus.resp_err_o   = 1'b0;
        bus.div_valid_o  = 1'b0;
        bus.busy_o       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Reset gating keeps every output low while rstn_i is held.
                if (win_vld && rstn_i) begin
                    bus.req_ready_o[win_idx] = 1'b1;
                    op_d.a  = bus.req_a_i[int'(win_idx)*32 +: 32];
                    op_d.b  = bus.req_b_i[int'(win_idx)*32 +: 32];
                    owner_d = win_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.div_valid_o = 1'b1;
                state_d         = WAIT;
            end
            WAIT: begin
                if (bus.div_done_i) begin
                    result_d = bus.div_result_i;
                    state_d  = RESP;
                end else if (timeout) begin
                    result_d = '0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                bus.resp_valid_o[owner_q] = 1'b1;
                bus.resp_data_o           = result_q;
                bus.resp_dbz_o            = (op_q.b[30:0] == 31'd0);
`ifdef FP32_DIV_ARB_WDOG_EN
                bus.resp_err_o            = err_q;
`endif
                rr_ptr_d = IW'((int'(owner_q) + 1) % N_REQ);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.div_a_o = op_q.a;
    assign bus.div_b_o = op_q.b;
endmodule

// File: tb/tb_fp32_div_arbiter.sv
// Bench for fp32_div_arbiter: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_fp32_div_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;
`ifdef FP32_DIV_ARB_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    fp32_div_arbiter_if #(.N_REQ(N)) bus ();

    fp32_div_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider stand-in: manual pulses from the main sequence or automatic random-latency replies.
    logic        man_done, auto_done, div_auto;
    logic [31:0] man_res, auto_res;
    assign bus.div_done_i   = man_done | auto_done;
    assign bus.div_result_i = man_done ? man_res : auto_res;

    logic [N-1:0] rv;
    logic [31:0]  ra [N];
    logic [31:0]  rb [N];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            bus.req_a_i[32*k +: 32] = ra[k];
            bus.req_b_i[32*k +: 32] = rb[k];
        end
        bus.req_valid_i = rv;
    endtask

    initial begin
        logic [31:0] a, b;
        auto_done = 1'b0;
        auto_res  = '0;
        forever begin
            @(negedge clk);
            if (div_auto && rstn && bus.div_valid_o) begin
                a = bus.div_a_o;
                b = bus.div_b_o;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
                auto_res  = a ^ {b[15:0], b[31:16]};
                auto_done = 1'b1;
                @(posedge clk);
                #1;
                auto_done = 1'b0;
            end
        end
    end

    // Reference model: one operation in flight, tracked by the cycle numbers of its events.
    int          cyc;
    bit          m_busy;
    int          m_acc, m_done, m_owner, m_ptr;
    logic [31:0] m_a, m_b, m_res;
    bit          m_err;
    int          grant_log[$];

    always @(negedge clk) begin : cmp
        logic [N-1:0] er, ev;
        int  win;
        bit  rc;
        cyc++;
        if (!rstn) begin
            chk("rst_ready",      32'(bus.req_ready_o),  32'd0);
            chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
            chk("rst_div_valid",  32'(bus.div_valid_o),  32'd0);
            chk("rst_busy",       32'(bus.busy_o),       32'd0);
            chk("rst_err",        32'(bus.resp_err_o),   32'd0);
            m_busy = 1'b0;
            m_ptr  = 0;
            m_done = -1;
            m_err  = 1'b0;
        end else begin
            er  = '0;
            win = -1;
            if (!m_busy) begin
                for (int i = 0; i < N; i++) begin
                    if (win < 0 && bus.req_valid_i[(m_ptr + i) % N]) win = (m_ptr + i) % N;
                end
            end
            if (win >= 0) er[win] = 1'b1;
            chk("ready", 32'(bus.req_ready_o), 32'(er));
            chk("busy", 32'(bus.busy_o), 32'(m_busy));
            chk("div_valid", 32'(bus.div_valid_o), 32'(m_busy && cyc == m_acc + 1));
            if (m_busy && cyc == m_acc + 1) begin
                chk("div_a", bus.div_a_o, m_a);
                chk("div_b", bus.div_b_o, m_b);
            end
            rc = m_busy && m_done >= 0 && cyc == m_done + 1;
            ev = '0;
            if (rc) ev[m_owner] = 1'b1;
            chk("resp_valid", 32'(bus.resp_valid_o), 32'(ev));
            chk("resp_dbz", 32'(bus.resp_dbz_o), 32'(rc && m_b[30:0] == 31'd0));
            chk("resp_err", 32'(bus.resp_err_o), 32'(rc && m_err));
            if (rc) chk("resp_data", bus.resp_data_o, m_res);

            if (rc) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end else if (m_busy && m_done < 0 && cyc > m_acc + 1) begin
                if (bus.div_done_i) begin
                    m_done = cyc;
                    m_res  = bus.div_result_i;
                    m_err  = 1'b0;
                end else if (WDOG && cyc - m_acc - 1 == TO) begin
                    m_done = cyc;
                    m_res  = '0;
                    m_err  = 1'b1;
                end
            end else if (!m_busy && win >= 0) begin
                m_busy  = 1'b1;
                m_acc   = cyc;
                m_done  = -1;
                m_owner = win;
                m_a     = bus.req_a_i[32*win +: 32];
                m_b     = bus.req_b_i[32*win +: 32];
                grant_log.push_back(win);
            end
        end
    end

    task automatic wait_grant(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: requester %0d got no grant within 20 cycles", k);
            rv = '0;
            drive_reqs();
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy_o && !m_busy) begin
                idle = 1'b1;
                break;
            end
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL drain_timeout: busy_o=%b still set after 200 cycles", bus.busy_o);
        end
        step();
    endtask

    // Single directed operation with hand-computed expectations; spur adds stray done pulses in ISSUE.
    task automatic one_op(input string nm, input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input bit exp_dbz, input bit spur);
        bit ok;
        int extra;
        logic [N-1:0] exp_rv;
        exp_rv    = '0;
        exp_rv[k] = 1'b1;
        ra[k] = a;
        rb[k] = b;
        rv    = exp_rv;
        drive_reqs();
        wait_grant(k, ok);
        if (ok) begin
            step();
            rv = '0;
            drive_reqs();
            man_res  = 32'hDEADBEEF;
            man_done = spur;
            @(negedge clk);
            chk({nm, "_div_valid"}, 32'(bus.div_valid_o), 32'd1);
            chk({nm, "_div_a"}, bus.div_a_o, a);
            chk({nm, "_div_b"}, bus.div_b_o, b);
            step();
            man_done = 1'b0;
            if (spur) begin
                @(negedge clk);
                chk({nm, "_no_early_resp"}, 32'(bus.resp_valid_o), 32'd0);
                repeat (3) step();
            end
            man_res  = res;
            man_done = 1'b1;
            step();
            man_done = 1'b0;
            @(negedge clk);
            chk({nm, "_resp_valid"}, 32'(bus.resp_valid_o), 32'(exp_rv));
            chk({nm, "_resp_data"}, bus.resp_data_o, res);
            chk({nm, "_resp_dbz"}, 32'(bus.resp_dbz_o), 32'(exp_dbz));
            extra = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                @(negedge clk);
                if (bus.resp_valid_o != '0) extra++;
            end
            chk({nm, "_single_resp"}, 32'(extra), 32'd0);
            step();
        end
    endtask

    task automatic run_random(input int ncyc);
        logic [N-1:0] hs;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            hs = bus.req_ready_o & bus.req_valid_i;
            step();
            for (int k = 0; k < N; k++) begin
                if (hs[k] || !rv[k]) begin
                    rv[k] = ($urandom_range(0, 99) < 40);
                    ra[k] = $urandom;
                    rb[k] = ($urandom_range(0, 5) == 0) ? {$urandom_range(0, 1) == 1, 31'd0} : $urandom;
                end
            end
            drive_reqs();
        end
    endtask

    initial begin
        bit ok;
        int n, spur_resp;
        int exp_order[5];
        total    = 0;
        bad      = 0;
        cyc      = 0;
        m_busy   = 1'b0;
        m_ptr    = 0;
        m_done   = -1;
        man_done = 1'b0;
        man_res  = '0;
        div_auto = 1'b0;
        rv       = '0;
        for (int k = 0; k < N; k++) begin
            ra[k] = '0;
            rb[k] = '0;
        end
        drive_reqs();
        rstn = 1'b0;
        repeat (3) step();
        chk("reset_div_a", bus.div_a_o, 32'd0);
        chk("reset_resp_data", bus.resp_data_o, 32'd0);
        rstn = 1'b1;
        step();

        // 6.0 / 2.0 = 3.0, then 1.0 / -0.0 flags divide-by-zero.
        one_op("div6by2", 0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        one_op("dbz_neg0", 2, 32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 1'b0);

        // Stray done pulses while idle must not produce a response.
        spur_resp = 0;
        man_res   = 32'h0BAD0BAD;
        man_done  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.resp_valid_o != '0) spur_resp++;
            step();
        end
        man_done = 1'b0;
        chk("idle_done_ignored", 32'(spur_resp), 32'd0);
        one_op("spur_issue", 1, 32'h41200000, 32'h40A00000, 32'h40000000, 1'b0, 1'b1);

        // Reset in the middle of WAIT with the pointer left at 2; 0 and 3 then compete.
        ra[1] = 32'h42C80000;
        rb[1] = 32'h41200000;
        rv    = 4'b0010;
        drive_reqs();
        wait_grant(1, ok);
        step();
        rv = '0;
        drive_reqs();
        step();
        ra[0] = 32'h3F800000; rb[0] = 32'h3F800000;
        ra[3] = 32'h40800000; rb[3] = 32'h40000000;
        rv    = 4'b1001;
        drive_reqs();
        rstn = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("midrst_busy", 32'(bus.busy_o), 32'd0);
        chk("midrst_div_a", bus.div_a_o, 32'd0);
        chk("midrst_div_b", bus.div_b_o, 32'd0);
        chk("midrst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        step();
        rstn     = 1'b1;
        man_res  = 32'h12345678;
        man_done = 1'b1;
        @(negedge clk);
        chk("midrst_first_grant", 32'(bus.req_ready_o), 32'h1);
        chk("midrst_late_done", 32'(bus.resp_valid_o), 32'd0);
        step();
        man_done = 1'b0;
        rv = '0;
        drive_reqs();
        step();
        man_res  = 32'h3F800000;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        @(negedge clk);
        chk("midrst_resp_owner0", 32'(bus.resp_valid_o), 32'h1);
        drain();

        // All four requesting continuously from a fresh reset.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        grant_log.delete();
        div_auto = 1'b1;
        rv = 4'hF;
        drive_reqs();
        n = 0;
        while (grant_log.size() < 5 && n < 300) begin
            step();
            n++;
        end
        rv = '0;
        drive_reqs();
        exp_order = '{0, 1, 2, 3, 0};
        total++;
        if (grant_log.size() < 5) begin
            bad++;
            $display("FAIL rr_order_timeout: %0d grants seen, 5 required", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) chk("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
        end
        drain();

        run_random(3000);
        rv = '0;
        drive_reqs();
        drain();
        div_auto = 1'b0;

        // Divider never answers.
        ra[0] = 32'h40000000;
        rb[0] = 32'h3F800000;
        rv    = 4'b0001;
        drive_reqs();
        wait_grant(0, ok);
        step();
        rv = '0;
        drive_reqs();
`ifdef FP32_DIV_ARB_WDOG_EN
        n = 1;
        while (n < 300) begin
            @(negedge clk);
            if (bus.resp_valid_o != '0) break;
            step();
            n++;
        end
        chk("wdog_resp_cycle", 32'(n), 32'(TO + 2));
        chk("wdog_err", 32'(bus.resp_err_o), 32'd1);
        chk("wdog_data", bus.resp_data_o, 32'd0);
        drain();
`else
        repeat (150) step();
        @(negedge clk);
        chk("nowdog_busy_held", 32'(bus.busy_o), 32'd1);
        chk("nowdog_no_resp", 32'(bus.resp_valid_o), 32'd0);
        step();
        man_res  = 32'h40000000;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        @(negedge clk);
        chk("nowdog_late_resp", 32'(bus.resp_valid_o), 32'h1);
        chk("nowdog_err", 32'(bus.resp_err_o), 32'd0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/fp32_div_arbiter.md
FP32_DIV_ARBITER -- requirements
Module: fp32_div_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the watchdog limit in cycles (used only with FP32_DIV_ARB_WDOG_EN).
REQ-003 The block SHALL have port clk_i, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rstn_i, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid_i, input, N_REQ, per-requester operation request.
REQ-006 The block SHALL have port req_ready_o, output, N_REQ, per-requester accept; one-hot or zero.
REQ-007 The block SHALL have port req_a_i, input, 32*N_REQ, dividends; requester k uses bits [32k+31:32k].
REQ-008 The block SHALL have port req_b_i, input, 32*N_REQ, divisors; same packing as req_a_i.
REQ-009 The block SHALL have port resp_valid_o, output, N_REQ, one-cycle result strobe to the owning requester.
REQ-010 The block SHALL have port resp_data_o, output, 32, FP32 quotient; valid only while any resp_valid_o bit is high.
REQ-011 The block SHALL have port resp_dbz_o, output, 1, divisor magnitude zero flag, qualified by resp_valid_o.
REQ-012 The block SHALL have port resp_err_o, output, 1, watchdog abort flag, qualified by resp_valid_o.
REQ-013 The block SHALL have port div_valid_o, output, 1, one-cycle start pulse to the divider.
REQ-014 The block SHALL have ports div_a_o and div_b_o, output, 32 each, registered operands to the divider.
REQ-015 The block SHALL have port div_result_i, input, 32, divider quotient, sampled when div_done_i is high.
REQ-016 The block SHALL have port div_done_i, input, 1, divider completion strobe.
REQ-017 The block SHALL have port busy_o, output, 1, high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with one operation in flight at a time.
REQ-019 In IDLE, the block SHALL assert req_ready_o for exactly one winner, chosen round-robin from rr_ptr upward among the requesters with req_valid_i high; req_ready_o SHALL be combinational.
REQ-020 On the handshake (valid and ready), the block SHALL capture the winner's operands into div_a_o/div_b_o, record the owner index, and go to ISSUE.
REQ-021 ISSUE SHALL assert div_valid_o for exactly one cycle, then go to WAIT; an accept-to-pulse latency of 1 cycle SHALL result.
REQ-022 WAIT SHALL hold until div_done_i, capture div_result_i into resp_data_o, and go to RESP.
REQ-023 RESP SHALL assert resp_valid_o[owner] for one cycle, set rr_ptr to (owner+1) mod N_REQ, and go to IDLE.
REQ-024 No requester SHALL be accepted in ISSUE, WAIT or RESP; req_ready_o SHALL be 0 there.
REQ-025 resp_dbz_o SHALL be 1 when the captured divisor bits [30:0] are zero; resp_data_o SHALL still pass the divider result through unchanged.
REQ-026 The block SHALL ignore div_done_i when not in WAIT.
REQ-027 The block SHALL give each continuously requesting requester a grant within N_REQ operations.
REQ-028 resp_valid_o, resp_dbz_o, resp_err_o and div_valid_o SHALL be 0 outside their qualifying state.

Reset
REQ-029 Asserting rstn_i at any time, including mid-operation, SHALL force IDLE, rr_ptr=0, all outputs 0, and the watchdog count 0; a pending divider result SHALL then be discarded via REQ-026.
REQ-030 After rstn_i deasserts, the first grant SHALL be available in the first cycle.

Configuration
REQ-031 With FP32_DIV_ARB_WDOG_EN defined, a counter SHALL run in WAIT; when the count reaches TIMEOUT without div_done_i, the block SHALL go to RESP with resp_data_o=0 and resp_err_o=1.
REQ-032 Without FP32_DIV_ARB_WDOG_EN, the block SHALL have no counter, WAIT SHALL be unbounded, and resp_err_o SHALL be tied to 0.

Verification
REQ-033 Req0: A=0x40C00000, B=0x40000000; model returns 0x40400000 -> div_valid_o one cycle after accept, resp_valid_o[0]=1, resp_data_o=0x40400000, dbz=0.
REQ-034 Req0..3 all valid continuously -> grant order 0,1,2,3,0; exactly one req_ready_o bit per IDLE cycle.
REQ-035 Req2: B=0x80000000 -> resp_dbz_o=1 with resp_valid_o[2].
REQ-036 Extra div_done_i pulses in IDLE and ISSUE -> no resp_valid_o; the real done pulse later -> a single response.
REQ-037 rstn_i pulsed low during WAIT -> all outputs 0, rr_ptr=0; a late div_done_i -> no response.
REQ-038 With WDOG_EN, TIMEOUT=64, no div_done_i -> resp_err_o=1 and resp_data_o=0 at the 64th WAIT cycle; without WDOG_EN -> busy_o stays 1.
